// File: rtl/dag_steal_arb.sv
// DAG1/DMA cycle-steal arbiter: round-robin over SPORT autobuffer channels.
// Optional BDMA requester enabled by defining DAG_STEAL_BDMA_EN.
module dag_steal_arb (
   input  logic       DSPCLK,
   input  logic       T_RST,
   input  logic       T0req,
   input  logic       T1req,
   input  logic       R0req,
   input  logic       R1req,
   input  logic       BDreq,
   input  logic [2:0] T0IREG,
   input  logic [2:0] T1IREG,
   input  logic [2:0] R0IREG,
   input  logic [2:0] R1IREG,
   input  logic [1:0] T0MREG,
   input  logic [1:0] T1MREG,
   input  logic [1:0] R0MREG,
   input  logic [1:0] R1MREG,
   input  logic       GO_C,
   input  logic       STBY,
   input  logic       redoM_h,
   output logic       STEAL,
   output logic [2:0] STEALI_R,
   output logic [1:0] STEALM_R,
   output logic [2:0] GNT_ID,
   output logic       T0sack,
   output logic       T1sack,
   output logic       R0sack,
   output logic       R1sack,
   output logic       BDsack
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EXEC  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic [2:0] GNT_BD   = 3'd4;
   localparam logic [2:0] GNT_NONE = 3'd7;

   state_t     state_q, state_d;
   logic [2:0] gnt_q, gnt_d;
   logic [2:0] ii_q, ii_d;
   logic [1:0] mm_q, mm_d;
   logic [1:0] ptr_q, ptr_d;

   logic [3:0] sp_req;
   logic       bd_req;
   logic       rr_hit;
   logic [1:0] rr_win;
   logic [1:0] cand;
   logic [2:0] win_i;
   logic [1:0] win_m;
   logic       in_ack;

   // Channel order on the round-robin ring: R0, T0, R1, T1
   assign sp_req = {T1req, R1req, T0req, R0req};

`ifdef DAG_STEAL_BDMA_EN
   assign bd_req = BDreq;
`else
   logic unused_bd;
   assign unused_bd = BDreq;
   assign bd_req    = 1'b0;
`endif

   // Scan from the slot after the last SPORT winner; nearest hit wins
   always_comb begin
      rr_hit = 1'b0;
      rr_win = ptr_q;
      cand   = ptr_q;
      for (int k = 4; k >= 1; k--) begin
         cand = ptr_q + 2'(k);
         if (sp_req[cand]) begin
            rr_hit = 1'b1;
            rr_win = cand;
         end
      end
   end

   always_comb begin
      win_i = 3'd0;
      win_m = 2'd0;
      unique case (rr_win)
         2'd0: begin win_i = R0IREG; win_m = R0MREG; end
         2'd1: begin win_i = T0IREG; win_m = T0MREG; end
         2'd2: begin win_i = R1IREG; win_m = R1MREG; end
         2'd3: begin win_i = T1IREG; win_m = T1MREG; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ii_d    = ii_q;
      mm_d    = mm_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (GO_C && !STBY && (rr_hit || bd_req)) begin
               state_d = GRANT;
               if (rr_hit) begin
                  gnt_d = {1'b0, rr_win};
                  ii_d  = win_i;
                  mm_d  = win_m;
               end else begin
                  gnt_d = GNT_BD;
                  ii_d  = 3'd0;
                  mm_d  = 2'd0;
               end
            end
         end
         GRANT: state_d = EXEC;
         EXEC: begin
            if (!redoM_h) state_d = ACK;
         end
         ACK: begin
            state_d = IDLE;
            // BDMA wins leave the SPORT ring position untouched
            if (!gnt_q[2]) ptr_d = gnt_q[1:0];
            gnt_d = GNT_NONE;
            ii_d  = 3'd0;
            mm_d  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge DSPCLK or posedge T_RST) begin
      if (T_RST) begin
         state_q <= IDLE;
         gnt_q   <= GNT_NONE;
         ii_q    <= 3'd0;
         mm_q    <= 2'd0;
         ptr_q   <= 2'd3;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ii_q    <= ii_d;
         mm_q    <= mm_d;
         ptr_q   <= ptr_d;
      end
   end

   assign in_ack   = (state_q == ACK);
   assign STEAL    = (state_q == GRANT) || (state_q == EXEC);
   assign STEALI_R = ii_q;
   assign STEALM_R = mm_q;
   assign GNT_ID   = gnt_q;
   assign R0sack   = in_ack && (gnt_q == 3'd0);
   assign T0sack   = in_ack && (gnt_q == 3'd1);
   assign R1sack   = in_ack && (gnt_q == 3'd2);
   assign T1sack   = in_ack && (gnt_q == 3'd3);

`ifdef DAG_STEAL_BDMA_EN
   assign BDsack = in_ack && (gnt_q == GNT_BD);
`else
   assign BDsack = 1'b0;
`endif

endmodule
